// File: rtl/regfile_write_sequencer.sv
// Sole owner of the register-file write port: zero-fills every register after reset,
// then shares the port between NUM_REQ writeback sources with round-robin arbitration.
module regfile_write_sequencer #(
    parameter int WIDTH         = 16,
    parameter int REGISTER_BITS = 4,
    parameter int NUM_REQ       = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*REGISTER_BITS-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]         req_data,
    output logic [NUM_REQ-1:0]               grant,
    output logic                             init_done,
    output logic                             rf_shouldWrite,
    output logic [REGISTER_BITS-1:0]         rf_writeAddress,
    output logic [WIDTH-1:0]                 rf_writeData
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [REGISTER_BITS-1:0] LAST_ADDR = '1;
    localparam logic [PTR_W-1:0]         LAST_REQ  = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        CLEAR,
        ARB
    } state_e;

    state_e                     state_q;
    logic [REGISTER_BITS-1:0]   clear_addr_q;
    logic [PTR_W-1:0]           rr_ptr_q;
    logic [NUM_REQ-1:0]         grant_q;
    logic                       init_done_q;
    logic                       wr_en_q;
    logic [REGISTER_BITS-1:0]   wr_addr_q;
    logic [WIDTH-1:0]           wr_data_q;

    logic [NUM_REQ-1:0]         eligible;
    logic                       win_valid;
    logic [PTR_W-1:0]           win_idx;
    logic [NUM_REQ-1:0]         grant_d;
    logic [REGISTER_BITS-1:0]   win_addr;
    logic [WIDTH-1:0]           win_data;
    logic [PTR_W-1:0]           rr_ptr_d;

    // Winner = lowest eligible index at or above rr_ptr, else lowest eligible overall.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        eligible  = req & ~grant_q;
        win_valid = 1'b0;
        win_idx   = '0;
        grant_d   = '0;
        win_addr  = '0;
        win_data  = '0;

        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_valid = 1'b1;
                win_idx   = PTR_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i] && (PTR_W'(i) >= rr_ptr_q)) begin
                win_idx = PTR_W'(i);
            end
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                grant_d[i] = win_valid;
                win_addr   = req_addr[i*REGISTER_BITS +: REGISTER_BITS];
                win_data   = req_data[i*WIDTH +: WIDTH];
            end
        end

        rr_ptr_d = (win_idx == LAST_REQ) ? '0 : win_idx + PTR_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= CLEAR;
            clear_addr_q <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            init_done_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    grant_q      <= '0;
                    wr_en_q      <= 1'b1;
                    wr_addr_q    <= clear_addr_q;
                    wr_data_q    <= '0;
                    clear_addr_q <= clear_addr_q + REGISTER_BITS'(1);
                    if (clear_addr_q == LAST_ADDR) begin
                        state_q     <= ARB;
                        init_done_q <= 1'b1;
                    end
                end
                ARB: begin
                    grant_q <= grant_d;
                    if (win_valid) begin
                        // r0 is hard-wired to zero, so its write is acknowledged but dropped.
                        wr_en_q   <= (win_addr != '0);
                        wr_addr_q <= win_addr;
                        wr_data_q <= win_data;
                        rr_ptr_q  <= rr_ptr_d;
                    end else begin
                        wr_en_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign grant           = grant_q;
    assign init_done       = init_done_q;
    assign rf_shouldWrite  = wr_en_q;
    assign rf_writeAddress = wr_addr_q;
    assign rf_writeData    = wr_data_q;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Bench for regfile_write_sequencer: directed scenarios plus randomized requesters
// checked against a round-robin reference model.
module tb_regfile_write_sequencer;

    localparam int W     = 16;
    localparam int RB    = 4;
    localparam int N     = 3;
    localparam int DEPTH = 1 << RB;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*RB-1:0]   req_addr;
    logic [N*W-1:0]    req_data;
    logic [N-1:0]      grant;
    logic              init_done;
    logic              rf_shouldWrite;
    logic [RB-1:0]     rf_writeAddress;
    logic [W-1:0]      rf_writeData;

    regfile_write_sequencer #(
        .WIDTH         (W),
        .REGISTER_BITS (RB),
        .NUM_REQ       (N)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req             (req),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .grant           (grant),
        .init_done       (init_done),
        .rf_shouldWrite  (rf_shouldWrite),
        .rf_writeAddress (rf_writeAddress),
        .rf_writeData    (rf_writeData)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pointer, last-cycle winner, expected registered outputs.
    int            m_ptr;
    int            m_last;
    logic [N-1:0]  exp_grant;
    logic          exp_sw;
    logic [RB-1:0] exp_addr;
    logic [W-1:0]  exp_data;

    logic [RB-1:0] cur_addr [N];
    logic [W-1:0]  cur_data [N];

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int c = (m_ptr + k) % N;
            if (req[c] && c != m_last) return c;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_addr[i*RB +: RB] = cur_addr[i];
            req_data[i*W +: W]   = cur_data[i];
        end
    endtask

    task automatic new_write(input int i, input bit allow_zero);
        req[i]      = 1'b1;
        cur_addr[i] = allow_zero ? RB'($urandom_range(DEPTH - 1, 0)) : RB'($urandom_range(DEPTH - 1, 1));
        cur_data[i] = W'($urandom);
        drive();
    endtask

    // Predict the outcome of the next edge from the current inputs, then let it happen.
    task automatic arb_edge();
        int w;
        w = pick();
        exp_grant = '0;
        if (w >= 0) begin
            exp_grant[w] = 1'b1;
            exp_addr     = req_addr[w*RB +: RB];
            exp_data     = req_data[w*W +: W];
            exp_sw       = (exp_addr != '0);
            m_ptr        = (w + 1) % N;
        end else begin
            exp_sw = 1'b0;
        end
        m_last = w;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({grant, init_done, rf_shouldWrite, rf_writeAddress, rf_writeData} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got grant=%b done=%b sw=%b addr=%h data=%h, want all zero",
                     grant, init_done, rf_shouldWrite, rf_writeAddress, rf_writeData);
        end
    endtask

    task automatic test_clear_walk();
        logic [RB-1:0] ea;
        logic          ed;
        for (int i = 0; i < N; i++) begin
            cur_addr[i] = RB'(3 + 4 * i);
            cur_data[i] = W'($urandom);
        end
        drive();
        req   = '1;
        reset = 1'b0;
        for (int e = 1; e <= DEPTH; e++) begin
            @(posedge clock);
            @(negedge clock);
            ea = RB'(e - 1);
            ed = (e == DEPTH);
            n_cmp++;
            if ({grant, rf_shouldWrite, rf_writeAddress, rf_writeData, init_done} !== {3'b000, 1'b1, ea, 16'h0000, ed}) begin
                n_bad++;
                $display("FAIL clear_walk edge %0d: got grant=%b sw=%b addr=%0d data=%h done=%b, want 000/1/%0d/0000/%b",
                         e, grant, rf_shouldWrite, rf_writeAddress, rf_writeData, init_done, ea, ed);
            end
        end
        m_ptr    = 0;
        m_last   = -1;
        exp_addr = RB'(DEPTH - 1);
        exp_data = '0;
        arb_edge();
        n_cmp++;
        if ({grant, rf_shouldWrite, rf_writeAddress, rf_writeData} !== {3'b001, 1'b1, cur_addr[0], cur_data[0]}) begin
            n_bad++;
            $display("FAIL first_grant: got grant=%b sw=%b addr=%0d data=%h, want 001/1/%0d/%h",
                     grant, rf_shouldWrite, rf_writeAddress, rf_writeData, cur_addr[0], cur_data[0]);
        end
        req = '0;
        arb_edge();
    endtask

    task automatic test_single_write();
        cur_addr[1] = 4'd5;
        cur_data[1] = 16'h1234;
        drive();
        req = 3'b010;
        arb_edge();
        n_cmp++;
        if ({grant, rf_shouldWrite, rf_writeAddress, rf_writeData} !== {3'b010, 1'b1, 4'd5, 16'h1234}) begin
            n_bad++;
            $display("FAIL single_write: got grant=%b sw=%b addr=%0d data=%h, want 010/1/5/1234",
                     grant, rf_shouldWrite, rf_writeAddress, rf_writeData);
        end
        req = '0;
        arb_edge();
        n_cmp++;
        if ({grant, rf_shouldWrite, rf_writeAddress, rf_writeData} !== {3'b000, 1'b0, 4'd5, 16'h1234}) begin
            n_bad++;
            $display("FAIL single_idle: got grant=%b sw=%b addr=%0d data=%h, want 000/0/5/1234 (held)",
                     grant, rf_shouldWrite, rf_writeAddress, rf_writeData);
        end
    endtask

    // The single write left the pointer at 2, so grants rotate 2,0,1,2,...
    task automatic test_round_robin();
        int            wi;
        logic [N-1:0]  eg;
        logic [RB-1:0] ea;
        logic [W-1:0]  ed;
        for (int i = 0; i < N; i++) new_write(i, 1'b0);
        for (int c = 0; c < 9; c++) begin
            wi = (2 + c) % N;
            eg = '0;
            eg[wi] = 1'b1;
            ea = cur_addr[wi];
            ed = cur_data[wi];
            arb_edge();
            n_cmp++;
            if ({grant, rf_shouldWrite, rf_writeAddress, rf_writeData} !== {eg, 1'b1, ea, ed}) begin
                n_bad++;
                $display("FAIL round_robin cycle %0d: got grant=%b sw=%b addr=%0d data=%h, want %b/1/%0d/%h",
                         c, grant, rf_shouldWrite, rf_writeAddress, rf_writeData, eg, ea, ed);
            end
            new_write(wi, 1'b0);
        end
        req = '0;
        arb_edge();
    endtask

    task automatic test_wrap();
        new_write(0, 1'b0);
        new_write(1, 1'b0);
        req[2] = 1'b0;
        arb_edge();
        n_cmp++;
        if ({grant, rf_writeAddress, rf_writeData} !== {3'b001, cur_addr[0], cur_data[0]}) begin
            n_bad++;
            $display("FAIL wrap_first: got grant=%b addr=%0d data=%h, want 001/%0d/%h",
                     grant, rf_writeAddress, rf_writeData, cur_addr[0], cur_data[0]);
        end
        req[0] = 1'b0;
        arb_edge();
        n_cmp++;
        if ({grant, rf_writeAddress, rf_writeData} !== {3'b010, cur_addr[1], cur_data[1]}) begin
            n_bad++;
            $display("FAIL wrap_second: got grant=%b addr=%0d data=%h, want 010/%0d/%h",
                     grant, rf_writeAddress, rf_writeData, cur_addr[1], cur_data[1]);
        end
        req = '0;
        arb_edge();
    endtask

    task automatic test_addr_zero();
        cur_addr[2] = '0;
        cur_data[2] = 16'hFFFF;
        drive();
        req = 3'b100;
        arb_edge();
        n_cmp++;
        if ({grant, rf_shouldWrite} !== {3'b100, 1'b0}) begin
            n_bad++;
            $display("FAIL addr_zero: got grant=%b sw=%b, want 100/0", grant, rf_shouldWrite);
        end
        req = '0;
        arb_edge();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            arb_edge();
            n_cmp++;
            if ({grant, rf_shouldWrite, rf_writeAddress, rf_writeData, init_done} !==
                {exp_grant, exp_sw, exp_addr, exp_data, 1'b1}) begin
                n_bad++;
                $display("FAIL random cycle %0d: got grant=%b sw=%b addr=%0d data=%h done=%b, want %b/%b/%0d/%h/1",
                         c, grant, rf_shouldWrite, rf_writeAddress, rf_writeData, init_done,
                         exp_grant, exp_sw, exp_addr, exp_data);
            end
            for (int i = 0; i < N; i++) begin
                if (exp_grant[i]) begin
                    if ($urandom_range(1, 0) == 1) new_write(i, 1'b1);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(2, 0) == 0) begin
                    new_write(i, 1'b1);
                end
            end
        end
        req = '0;
        arb_edge();
    endtask

    task automatic test_reset_mid_grant();
        logic [RB-1:0] ea;
        new_write(1, 1'b0);
        req[0] = 1'b0;
        req[2] = 1'b0;
        arb_edge();
        n_cmp++;
        if (grant !== 3'b010) begin
            n_bad++;
            $display("FAIL pre_reset_grant: got grant=%b, want 010", grant);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({grant, init_done, rf_shouldWrite, rf_writeAddress, rf_writeData} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got grant=%b done=%b sw=%b addr=%h data=%h before next edge, want all zero",
                     grant, init_done, rf_shouldWrite, rf_writeAddress, rf_writeData);
        end
        @(negedge clock);
        req   = '1;
        reset = 1'b0;
        for (int e = 0; e < 2; e++) begin
            @(posedge clock);
            @(negedge clock);
            ea = RB'(e);
            n_cmp++;
            if ({grant, init_done, rf_shouldWrite, rf_writeAddress, rf_writeData} !== {3'b000, 1'b0, 1'b1, ea, 16'h0000}) begin
                n_bad++;
                $display("FAIL restart_walk edge %0d: got grant=%b done=%b sw=%b addr=%0d data=%h, want 000/0/1/%0d/0000",
                         e, grant, init_done, rf_shouldWrite, rf_writeAddress, rf_writeData, ea);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_walk();
        test_single_write();
        test_round_robin();
        test_wrap();
        test_addr_zero();
        test_random();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
